// File: rtl/act_vec_assembler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : act_vec_assembler
// Purpose  : Stream-to-vector activation buffer for one layer of N-input
//            float MAC/ReLU nodes. Collects W-bit words from a valid/ready
//            stream into N-word vectors held in two ping-pong banks and
//            presents the oldest complete vector in parallel.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            s_data     - incoming activation word
//            s_valid    - s_data valid
//            s_last     - final word of a vector (framing marker)
//            s_ready    - buffer accepts a word this cycle
//            m_vec      - assembled vector, word i at [i*W +: W] -> node Ai
//            m_valid    - m_vec holds a complete vector
//            m_ready    - node layer captures m_vec
//            frame_err  - one-cycle pulse per mis-framed word
//            frames_out - count of vectors handed off (wraps 0xFFFF -> 0)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module act_vec_assembler #(
    parameter int N = 15,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   s_data,
    input  logic           s_valid,
    input  logic           s_last,
    output logic           s_ready,
    output logic [N*W-1:0] m_vec,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           frame_err,
    output logic [15:0]    frames_out
);

    localparam int            CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    // Storage: two banks of N words plus a full flag per bank.
    logic [N-1:0][W-1:0] r_bank [2];
    logic [1:0]          r_full;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [CW-1:0]       r_wr_cnt;
    // Held low through reset and for the first edge after it, so s_ready
    // only rises once the block is clocked out of reset.
    logic                r_started;
    logic                r_frame_err;
    logic [15:0]         r_frames_out;

    logic w_beat;
    logic w_at_end;
    logic w_short;
    logic w_store;
    logic w_commit;
    logic w_long;
    logic w_release;

    // s_ready depends on registered state only; m_ready never reaches it.
    assign s_ready   = r_started && !r_full[r_wr_bank];
    assign m_valid   = r_full[r_rd_bank];
    assign m_vec     = r_bank[r_rd_bank];
    assign frame_err = r_frame_err;
    assign frames_out = r_frames_out;

    assign w_beat    = s_valid && s_ready;
    assign w_at_end  = (r_wr_cnt == C_LAST);
    // A marker before the last slot aborts the partial vector; the marked
    // word itself is discarded with it.
    assign w_short   = w_beat && s_last && !w_at_end;
    assign w_store   = w_beat && !w_short;
    assign w_commit  = w_beat && w_at_end;
    // Missing marker on the last slot is flagged but the vector still commits.
    assign w_long    = w_commit && !s_last;
    assign w_release = m_valid && m_ready;

    // Word storage. Writes only ever target a bank that is not full, so the
    // bank being presented on m_vec is never disturbed while m_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank[0] <= '0;
            r_bank[1] <= '0;
        end else if (w_store) begin
            r_bank[r_wr_bank][r_wr_cnt] <= s_data;
        end
    end

    // Write pointer, slot counter and framing error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started   <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_started   <= 1'b1;
            r_frame_err <= w_short || w_long;
            if (w_short || w_commit) begin
                r_wr_cnt <= '0;
            end else if (w_store) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (w_commit) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // Full flags, read pointer and hand-off counter. A commit and a release
    // in the same cycle always address different banks (writes go to empty
    // banks, releases to full ones), so both updates apply independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full       <= 2'b00;
            r_rd_bank    <= 1'b0;
            r_frames_out <= 16'h0000;
        end else begin
            if (w_commit) begin
                r_full[r_wr_bank] <= 1'b1;
            end
            if (w_release) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
                r_frames_out      <= r_frames_out + 16'h0001;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_act_vec_assembler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_act_vec_assembler
// Purpose  : Self-checking bench for act_vec_assembler. A directed table,
//            hand-written multi-cycle sequences and a randomized phase, all
//            checked against a queue-based model of the buffer.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_act_vec_assembler;

    localparam int N  = 15;
    localparam int W  = 32;
    localparam int VW = N * W;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   s_data;
    logic           s_valid;
    logic           s_last;
    logic           s_ready;
    logic [VW-1:0]  m_vec;
    logic           m_valid;
    logic           m_ready;
    logic           frame_err;
    logic [15:0]    frames_out;

    act_vec_assembler #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_vec      (m_vec),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_err  (frame_err),
        .frames_out (frames_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: completed vectors waiting for hand-off, plus the
    // words of the vector currently being collected.
    logic [VW-1:0] mq[$];
    logic [W-1:0]  part[$];
    bit            m_started;
    bit            m_err;
    logic [15:0]   m_frames;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        mr;
        logic        e_ready;
        logic        e_valid;
        logic        e_err;
        logic [15:0] e_frames;
    } row_t;

    row_t tbl[40];

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic bit model_ready();
        return m_started && (mq.size() < 2);
    endfunction

    task automatic model_reset();
        mq.delete();
        part.delete();
        m_started = 0;
        m_err     = 0;
        m_frames  = 16'h0000;
    endtask

    // One clock edge of the model, evaluated from pre-edge state.
    task automatic model_edge(input logic v, input logic [31:0] d, input logic l, input logic mr);
        bit rdy;
        bit vld;
        logic [VW-1:0] vec;
        rdy   = model_ready();
        vld   = (mq.size() > 0);
        m_err = 0;
        if (vld && mr) begin
            void'(mq.pop_front());
            m_frames = m_frames + 16'd1;
        end
        if (v && rdy) begin
            if (l && part.size() < N - 1) begin
                m_err = 1;
                part.delete();
            end else begin
                part.push_back(d);
                if (part.size() == N) begin
                    if (!l) m_err = 1;
                    vec = '0;
                    for (int i = 0; i < N; i++) vec[i*W +: W] = part[i];
                    mq.push_back(vec);
                    part.delete();
                end
            end
        end
        m_started = 1;
    endtask

    task automatic check_outputs();
        chk("s_ready",    VW'(s_ready),    VW'(model_ready()));
        chk("m_valid",    VW'(m_valid),    VW'(mq.size() > 0));
        chk("frame_err",  VW'(frame_err),  VW'(m_err));
        chk("frames_out", VW'(frames_out), VW'(m_frames));
        if (mq.size() > 0) chk("m_vec", m_vec, mq[0]);
    endtask

    // Called at a falling edge: drive, advance one clock, check at next fall.
    task automatic apply(input logic v, input logic [31:0] d, input logic l, input logic mr);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = mr;
        model_edge(v, d, l, mr);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // Asserts reset asynchronously mid-cycle and checks outputs at once.
    task automatic do_reset();
        s_valid = 0; s_last = 0; m_ready = 0; s_data = '0;
        #1 rst_n = 0;
        #1;
        model_reset();
        chk("rst_s_ready",   VW'(s_ready),    '0);
        chk("rst_m_valid",   VW'(m_valid),    '0);
        chk("rst_m_vec",     m_vec,           '0);
        chk("rst_frame_err", VW'(frame_err),  '0);
        chk("rst_frames",    VW'(frames_out), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        // First edge after release: s_ready still low before it.
        chk("rst_rel_ready", VW'(s_ready), '0);
        apply(0, '0, 0, 0);
    endtask

    initial begin : main
        int idx;
        int hold;
        int errs;
        bit pulsed;
        logic l;

        // Directed table.
        for (int i = 0; i < 15; i++)
            tbl[i] = '{1'b1, 32'h3F800000 + i, (i == 14), 1'b1, 1'b1, (i == 14), 1'b0, 16'd0};
        tbl[15] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
        for (int k = 0; k < 7; k++)
            tbl[16+k] = '{1'b1, 32'h40000000 + k, (k == 6), 1'b0, 1'b1, 1'b0, (k == 6), 16'd1};
        tbl[23] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
        for (int k = 0; k < 15; k++)
            tbl[24+k] = '{1'b1, 32'h41000000 + k, (k == 14), 1'b0, 1'b1, (k == 14), 1'b0, 16'd1};
        tbl[39] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2};

        rst_n = 1; s_valid = 0; s_last = 0; m_ready = 0; s_data = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 40; i++) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr);
            chk("tbl_ready",  VW'(s_ready),    VW'(tbl[i].e_ready));
            chk("tbl_valid",  VW'(m_valid),    VW'(tbl[i].e_valid));
            chk("tbl_err",    VW'(frame_err),  VW'(tbl[i].e_err));
            chk("tbl_frames", VW'(frames_out), VW'(tbl[i].e_frames));
            if (i == 14) begin
                chk("tbl_vec_w0",  VW'(m_vec[0*W +: W]),  VW'(32'h3F800000));
                chk("tbl_vec_w14", VW'(m_vec[14*W +: W]), VW'(32'h3F80000E));
            end
            if (i == 38) chk("tbl_vec2_w0", VW'(m_vec[0 +: W]), VW'(32'h41000000));
        end

        // 45 continuous words with the consumer stalled.
        idx = 0; hold = 0; pulsed = 0;
        for (int cyc = 0; cyc < 300 && idx < 45; cyc++) begin
            logic mr;
            bit rdy;
            mr  = (idx == 30 && hold >= 3 && !pulsed);
            rdy = model_ready();
            apply(1, 32'h50000000 + idx, (idx % 15 == 14), mr);
            if (mr) pulsed = 1;
            if (rdy) begin
                idx++;
                if (idx == 30) chk("holdoff_ready", VW'(s_ready), '0);
            end else if (idx == 30) begin
                hold++;
            end
        end
        chk("w45_done", VW'(idx), VW'(45));
        for (int k = 0; k < 4; k++) apply(0, '0, 0, 1);

        // Long frame: no marker on word 15; word 16 starts the next vector.
        errs = 0;
        for (int k = 0; k < 30; k++) begin
            apply(1, 32'hC0000000 + k, (k == 29), 1);
            if (frame_err) errs++;
            if (k == 29) chk("long_next_w0", VW'(m_vec[0 +: W]), VW'(32'hC000000F));
        end
        chk("long_err_count", VW'(errs), VW'(1));
        apply(0, '0, 0, 1);

        // Reset with one bank full and the other half written.
        for (int k = 0; k < 22; k++) apply(1, 32'hD0000000 + k, (k == 14), 0);
        do_reset();
        for (int k = 0; k < 15; k++) apply(1, 32'hE0000000 + k, (k == 14), 0);
        chk("post_rst_w3", VW'(m_vec[3*W +: W]), VW'(32'hE0000003));
        apply(0, '0, 0, 1);

        // Hand-off counter wrap.
        force dut.r_frames_out = 16'hFFFE;
        #1 release dut.r_frames_out;
        m_frames = 16'hFFFE;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 15; k++) apply(1, 32'hF0000000 + k, (k == 14), 0);
            apply(0, '0, 0, 1);
            chk("wrap_frames", VW'(frames_out), VW'(f == 0 ? 16'hFFFF : 16'h0000));
        end

        // Randomized traffic, mostly well framed with occasional marker errors.
        for (int c = 0; c < 3000; c++) begin
            l = (part.size() == N - 1);
            if ($urandom_range(0, 29) == 0) l = ~l;
            apply(($urandom_range(0, 3) != 0), $urandom, l, ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
